muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller attached beside the execution-stage ALU. It accepts MULT/MULTU/DIV/DIVU operands taken after the forwarding muxes and runs a 32-iteration shift-add or restoring-divide datapath. It owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. It drives a stall to the hazard logic whenever the pipeline would otherwise read or overwrite a result still in flight.

Parameters:
WIDTH, 32, operand and HI/LO width.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request from EX; valid only when the op code is a MULT/DIV type.
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
op_a  input  WIDTH  forwarded rs value (bus A after the forwarding mux).
op_b  input  WIDTH  forwarded rt value (bus B after the forwarding mux).
busy  output  1  operation in flight.
done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
stall  output  1  freeze IF/ID/EX latches this cycle.
hi_lo_out  output  WIDTH  HI or LO value for MFHI/MFLO, muxed into ALU_out.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, HI=LO=0, count=0, busy=0, done=0, stall=0, hi_lo_out=0. Reset asserted mid-operation aborts it. No done pulse is produced and HI/LO read 0 afterwards.
- States:
  - IDLE -> MUL on start with op 0/1.
  - IDLE -> DIV on start with op 2/3.
  - MUL/DIV -> FIX when count reaches WIDTH-1.
  - FIX -> IDLE. HI/LO are written and done=1 during the FIX->IDLE edge.
- Signed ops: operands are converted to magnitude on accept, and the sign flags are latched.
  - In FIX, the product is negated if sign_a XOR sign_b.
  - For DIV, the quotient (LO) is negated if sign_a XOR sign_b, and the remainder (HI) takes the sign of the dividend.
- Multiply: 2*WIDTH accumulator, one add/shift per cycle.
- Divide: restoring; one subtract/shift per cycle. Quotient goes to LO, remainder to HI.
- Latency: accept cycle + WIDTH iterations + FIX = WIDTH+2 cycles from start to done (34 at WIDTH=32). busy is high from the cycle after accept until done, inclusive.
- Divide by zero: runs the full latency. Result is LO=all ones, HI=dividend (raw op_a, sign preserved). No exception.
- MTHI/MTLO:
  - In IDLE: write HI/LO from op_a at the next edge, no stall.
  - While busy: stall until the FIX edge; the write then lands one cycle after done and overrides the MULT/DIV result.
- MFHI/MFLO:
  - hi_lo_out is combinational from the HI/LO registers when not busy.
  - While busy: stall=1 until the cycle after done, then the new value is returned.
- start while busy: stall=1; the request is held by the frozen EX latch and accepted in the cycle after done.
- stall is combinational: busy AND (start OR op in 4..7 with an EX-valid op). Otherwise stall=0; independent MULT/DIV overlaps with ALU instructions.
- Simultaneous done and a new start: the new start is accepted in the following cycle (one idle bubble). Back-to-back ops therefore take WIDTH+3 cycles each.
- A start with op 4..7 is ignored by the FSM. Those ops use the MT/MF paths above.

Decomposition:
- Shared package (muldiv_pkg): op encodings (OP_MULT..OP_MFLO), state encoding (IDLE, MUL, DIV, FIX), WIDTH default.
- One natural sub-module: muldiv_core.
  - Holds the accumulator/remainder shift register and the adder/subtractor.
  - Inputs: iterate, mode, load. Output: raw 2*WIDTH result.
- muldiv_sequencer holds the FSM, counter, sign fixup, HI/LO and stall logic.

Test Plan:
- MULT op_a=-3 (0xFFFFFFFD), op_b=7 -> done at cycle 34 after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 34 cycles.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
- MFLO issued 5 cycles after a MULT start -> stall held until the cycle after done, then hi_lo_out equals the new LO. MFHI in IDLE -> no stall, immediate value.
- Back-to-back MULT, MULT -> the second start stalls and is accepted one cycle after the first done; the second done lands 35 cycles after the first.
- rst_n pulsed low at iteration 10 of a DIV -> busy=0, HI=LO=0, no done. A subsequent MTHI 0x1234 writes HI=0x1234 with no stall.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, default widths.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 6;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // True for the op codes that launch a multi-cycle MULT/DIV.
    function automatic logic is_muldiv(input logic [2:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 iterate,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    acc;
    logic [W2-1:0]    acc_d;
    logic [WIDTH-1:0] breg;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [W2-1:0]    div_next;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, breg} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, breg};
        div_diff  = div_shift[WIDTH-1:0] - breg;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

        acc_d = acc;
        if (load) begin
            acc_d = {WIDTH'(0), a_mag};
        end else if (iterate) begin
            acc_d = mode ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            breg <= '0;
        end else begin
            acc <= acc_d;
            if (load) begin
                breg <= b_mag;
            end
        end
    end

    assign result = acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/DIV controller: FSM, iteration count, sign fix-up, HI/LO registers and pipeline stall.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi_lo_out
);

    localparam int unsigned    W2   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic             busy_d;
    logic             done_d;
    logic             accept_c;
    logic             fix_c;

    logic             op_signed_c;
    logic             sign_a_c;
    logic             sign_b_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;

    logic             sign_a;
    logic             sign_b;
    logic             is_div;
    logic             div_zero;
    logic [WIDTH-1:0] raw_a;

    logic [W2-1:0]    raw_res;
    logic [W2-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // A request held while busy is only taken once busy has dropped (one idle bubble).
    assign accept_c = (state == ST_IDLE) && !busy && start && is_muldiv(op);

    // Operand conditioning: signed ops run on magnitudes.
    always_comb begin
        op_signed_c = ~op[0];
        sign_a_c    = op_signed_c & op_a[WIDTH-1];
        sign_b_c    = op_signed_c & op_b[WIDTH-1];
        mag_a_c     = sign_a_c ? (~op_a + WIDTH'(1)) : op_a;
        mag_b_c     = sign_b_c ? (~op_b + WIDTH'(1)) : op_b;
    end

    always_comb begin
        state_d = state;
        count_d = count;
        busy_d  = busy;
        done_d  = 1'b0;
        fix_c   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy_d = accept_c;
                if (accept_c) begin
                    state_d = op[1] ? ST_DIV : ST_MUL;
                    count_d = '0;
                end
            end
            ST_MUL, ST_DIV: begin
                count_d = count + CNT_W'(1);
                if (count == LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b1;
                fix_c   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Operation context captured at accept for the final fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            raw_a    <= '0;
        end else if (accept_c) begin
            sign_a   <= sign_a_c;
            sign_b   <= sign_b_c;
            is_div   <= op[1];
            div_zero <= (op_b == '0);
            raw_a    <= op_a;
        end
    end

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_c),
        .iterate ((state == ST_MUL) || (state == ST_DIV)),
        .mode    (state == ST_DIV),
        .a_mag   (mag_a_c),
        .b_mag   (mag_b_c),
        .result  (raw_res)
    );

    // Remainder follows the dividend's sign; quotient and product follow sign_a ^ sign_b.
    always_comb begin
        prod_c = (sign_a ^ sign_b) ? (~raw_res + W2'(1)) : raw_res;
        quot_c = (sign_a ^ sign_b) ? (~raw_res[WIDTH-1:0] + WIDTH'(1)) : raw_res[WIDTH-1:0];
        rem_c  = sign_a ? (~raw_res[W2-1:WIDTH] + WIDTH'(1)) : raw_res[W2-1:WIDTH];
    end

    always_comb begin
        hi_d = hi;
        lo_d = lo;
        if (fix_c) begin
            if (is_div && div_zero) begin
                hi_d = raw_a;
                lo_d = '1;
            end else if (is_div) begin
                hi_d = rem_c;
                lo_d = quot_c;
            end else begin
                hi_d = prod_c[W2-1:WIDTH];
                lo_d = prod_c[WIDTH-1:0];
            end
        end else if (!busy) begin
            if (op == OP_MTHI) begin
                hi_d = op_a;
            end
            if (op == OP_MTLO) begin
                lo_d = op_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= hi_d;
            lo <= lo_d;
        end
    end

    // Stall and the MF read path are combinational so EX sees them in the same cycle.
    always_comb begin
        stall = busy & (start | op[2]);
        unique case (op)
            OP_MFHI: hi_lo_out = hi;
            OP_MFLO: hi_lo_out = lo;
            default: hi_lo_out = '0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops vs arithmetic model, corner sequences.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi_lo_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .hi_lo_out (hi_lo_out)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic; SV signed / and % truncate toward zero like the ISA.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (o)
            OP_MULT: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = '1;
                end else begin
                    if (o == OP_DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    hi = 32'(r);
                    lo = 32'(q);
                end
            end
        endcase
    endfunction

    task automatic read_hilo(output logic [31:0] rh, output logic [31:0] rl);
        op = OP_MFHI;
        #1 rh = hi_lo_out;
        op = OP_MFLO;
        #1 rl = hi_lo_out;
        op = OP_MULT;
    endtask

    // Launch one MULT/DIV from idle, check latency, busy span, done width and results.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          cyc;
        int          done_cyc;
        int          busy_cnt;
        logic [31:0] rh;
        logic [31:0] rl;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op    = OP_MULT;
        op_a  = $urandom;
        op_b  = $urandom;
        cyc      = 1;
        done_cyc = -1;
        busy_cnt = 0;
        while (done_cyc < 0 && cyc < 80) begin
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " latency"}, 32'(done_cyc), 32'd34);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd34);
        @(negedge clk);
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        read_hilo(rh, rl);
        check({tag, " hi"}, rh, exp_hi);
        check({tag, " lo"}, rl, exp_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          d1;
        int          d2;
        int          acc_cyc;
        bit          seen_done;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] rh;
        logic [31:0] rl;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6] = '{OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        read_hilo(rh, rl);
        check("reset hi", rh, 32'd0);
        check("reset lo", rl, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = ~32'($urandom_range(0, 8));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            ref_model(o, a, b, eh, el);
            do_op($sformatf("rnd%0d op%0d a=%h b=%h", i, o, a, b), o, a, b, eh, el);
        end

        // MFLO five cycles into a MULT: held until the cycle after done.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        op_a  = 32'h00012345;
        op_b  = 32'h00010000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = OP_MFLO;
        #1;
        cyc = 5;
        while (stall && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("mflo stall release cycle", 32'(cyc), 32'd35);
        check("mflo new value", hi_lo_out, 32'h23450000);
        op = OP_MFHI;
        #1;
        check("mfhi idle stall", 32'(stall), 32'd0);
        check("mfhi idle value", hi_lo_out, 32'h00000001);
        op = OP_MULT;

        // Back-to-back MULTs: second start frozen in EX until the cycle after the first done.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        op_a  = 32'd7;
        op_b  = 32'd9;
        @(negedge clk);
        op_a    = 32'hFFFFFFFF;
        op_b    = 32'd5;
        cyc     = 1;
        d1      = -1;
        d2      = -1;
        acc_cyc = -1;
        while (d2 < 0 && cyc < 150) begin
            #1;
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            if (start && !stall && acc_cyc < 0) acc_cyc = cyc;
            @(negedge clk);
            cyc++;
            if (acc_cyc >= 0) start = 1'b0;
        end
        start = 1'b0;
        check("b2b first done", 32'(d1), 32'd34);
        check("b2b second accept", 32'(acc_cyc), 32'd35);
        check("b2b done spacing", 32'(d2 - d1), 32'd35);
        read_hilo(rh, rl);
        check("b2b hi", rh, 32'hFFFFFFFF);
        check("b2b lo", rl, 32'hFFFFFFFB);

        // MTLO while busy: stalled, then overrides the MULT result.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        op_a  = 32'd3;
        op_b  = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op   = OP_MTLO;
        op_a = 32'h0000ABCD;
        #1;
        check("mtlo busy stall", 32'(stall), 32'd1);
        cyc = 3;
        while (stall && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("mtlo stall release cycle", 32'(cyc), 32'd35);
        @(negedge clk);
        op = OP_MULT;
        read_hilo(rh, rl);
        check("mtlo busy hi", rh, 32'd0);
        check("mtlo busy lo", rl, 32'h0000ABCD);

        // Reset at iteration 10 of a DIV aborts it and clears HI/LO.
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        op_a  = 32'd1000;
        op_b  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op    = OP_MULT;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort no done", 32'(seen_done), 32'd0);
        read_hilo(rh, rl);
        check("abort hi", rh, 32'd0);
        check("abort lo", rl, 32'd0);
        op   = OP_MTHI;
        op_a = 32'h00001234;
        #1;
        check("mthi idle stall", 32'(stall), 32'd0);
        @(negedge clk);
        op = OP_MFHI;
        #1;
        check("mthi idle hi", hi_lo_out, 32'h00001234);
        op = OP_MULT;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
